// File: rtl/td4_clk_pkg.sv
// Shared types and reset levels for the TD4 clock-control stage.
package td4_clk_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 2'd0,
    STEP     = 2'd1,
    WAIT_REL = 2'd2,
    RUN      = 2'd3
  } state_t;

  localparam logic BTN_RST_LEVEL = 1'b1;  // released
  localparam logic SW_RST_LEVEL  = 1'b0;
endpackage

// File: rtl/td4_debounce.sv
// Button synchroniser + debouncer; emits a registered pulse one cycle after
// the accepted level falls.
module td4_debounce
  import td4_clk_pkg::*;
#(
  parameter int CNT_W           = 24,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_raw,
  output logic level,
  output logic fall_pulse
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2, level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1         <= BTN_RST_LEVEL;
      s2         <= BTN_RST_LEVEL;
      level      <= BTN_RST_LEVEL;
      level_d    <= BTN_RST_LEVEL;
      fall_pulse <= 1'b0;
      cnt        <= '0;
    end else begin
      s1         <= in_raw;
      s2         <= s1;
      level_d    <= level;
      fall_pulse <= level_d & ~level;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt >= CNT_LAST) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/td4_clock_ctrl.sv
// TD4 clock-enable generator: free-run divider or debounced single-step,
// with heartbeat LED and visible FSM state.
module td4_clock_ctrl
  import td4_clk_pkg::*;
#(
  parameter int CNT_W           = 24,
  parameter int DIV_SLOW        = 12000000,
  parameter int DIV_FAST        = 1200000,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               mode_run,
  input  logic               speed_fast,
  input  logic               step_btn_n,
  output logic               tick,
  output logic               tick_led,
  output logic [STATE_W-1:0] state
);
  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(DIV_SLOW - 1);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(DIV_FAST - 1);

  logic [1:0]       mode_sync, fast_sync;
  logic             mode_run_s, speed_fast_s;
  logic             btn_level, btn_fall;
  state_t           st, st_next;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_last;
  logic             tick_next;

  td4_debounce #(
    .CNT_W          (CNT_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_raw    (step_btn_n),
    .level     (btn_level),
    .fall_pulse(btn_fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_sync <= {2{SW_RST_LEVEL}};
      fast_sync <= {2{SW_RST_LEVEL}};
    end else begin
      mode_sync <= {mode_sync[0], mode_run};
      fast_sync <= {fast_sync[0], speed_fast};
    end
  end

  assign mode_run_s   = mode_sync[1];
  assign speed_fast_s = fast_sync[1];
  assign cnt_last     = speed_fast_s ? FAST_LAST : SLOW_LAST;

  // Divider only survives while staying in RUN; every other path clears it.
  always_comb begin
    st_next   = st;
    cnt_next  = '0;
    tick_next = 1'b0;
    case (st)
      IDLE: begin
        if (mode_run_s) begin
          st_next = RUN;
        end else if (btn_fall) begin
          st_next   = STEP;
          tick_next = 1'b1;
        end
      end
      STEP: st_next = WAIT_REL;
      WAIT_REL: begin
        if (mode_run_s)     st_next = RUN;
        else if (btn_level) st_next = IDLE;
      end
      RUN: begin
        if (!mode_run_s) begin
          st_next = btn_level ? IDLE : WAIT_REL;
        end else if (cnt >= cnt_last) begin
          tick_next = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st       <= IDLE;
      cnt      <= '0;
      tick     <= 1'b0;
      tick_led <= 1'b0;
    end else begin
      st       <= st_next;
      cnt      <= cnt_next;
      tick     <= tick_next;
      tick_led <= tick_led ^ tick_next;
    end
  end

  assign state = st;
endmodule

// File: tb/tb_td4_clock_ctrl.sv
// Directed scenarios plus random stimulus for td4_clock_ctrl, checked each
// cycle against a behavioural model and at key points against fixed values.
module tb_td4_clock_ctrl;
  localparam int D    = 4;
  localparam int SLOW = 10;
  localparam int FAST = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       mode_run = 1'b0;
  logic       speed_fast = 1'b0;
  logic       step_btn_n = 1'b1;
  logic       tick, tick_led;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;

  td4_clock_ctrl #(
    .CNT_W(24), .DIV_SLOW(SLOW), .DIV_FAST(FAST), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk), .reset_n(reset_n), .mode_run(mode_run), .speed_fast(speed_fast),
    .step_btn_n(step_btn_n), .tick(tick), .tick_led(tick_led), .state(state)
  );

  always #5 clk = ~clk;

  // Model: raw input history (value seen two edges ago is what logic acts on),
  // accepted button level via run of D disagreeing samples, elapsed-cycles divider.
  bit hb[2], hm[2], hf[2];
  bit acc;
  int streak;
  bit fell[2];
  int m_st, elapsed;
  bit m_tick, m_led;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hb = '{1'b1, 1'b1}; hm = '{1'b0, 1'b0}; hf = '{1'b0, 1'b0};
    acc = 1'b1; streak = 0; fell = '{1'b0, 1'b0};
    m_st = 0; elapsed = 0; m_tick = 1'b0; m_led = 1'b0;
  endtask

  task automatic model_edge();
    bit b, m, f, press, fell_now;
    b = hb[1]; m = hm[1]; f = hf[1]; press = fell[1];
    m_tick = 1'b0;
    case (m_st)
      0: if (m) begin m_st = 3; elapsed = 0; end
         else if (press) begin m_st = 1; m_tick = 1'b1; end
      1: m_st = 2;
      2: if (m) begin m_st = 3; elapsed = 0; end
         else if (acc) m_st = 0;
      default: begin
        if (!m) begin
          m_st = acc ? 0 : 2; elapsed = 0;
        end else begin
          elapsed++;
          if (elapsed >= (f ? FAST : SLOW)) begin m_tick = 1'b1; elapsed = 0; end
        end
      end
    endcase
    m_led ^= m_tick;
    fell_now = 1'b0;
    if (b != acc) begin
      streak++;
      if (streak == D) begin acc = b; streak = 0; fell_now = !b; end
    end else begin
      streak = 0;
    end
    fell[1] = fell[0]; fell[0] = fell_now;
    hb[1] = hb[0]; hb[0] = step_btn_n;
    hm[1] = hm[0]; hm[0] = mode_run;
    hf[1] = hf[0]; hf[0] = speed_fast;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("tick", tick, m_tick);
    chk("tick_led", tick_led, m_led);
    chk("state", state, m_st);
    if (tick) tick_cnt++;
  endtask

  initial begin
    int st_log[64];
    int tk_log[64];
    int first, rel, entry, led0, t;
    int q[$];

    model_reset();
    #12;
    chk("rst_tick", tick, 0);
    chk("rst_led", tick_led, 0);
    chk("rst_state", state, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) cycle();

    // Single step: one tick D+3 edges after the first edge sampling the press.
    tick_cnt = 0; first = -1;
    step_btn_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      st_log[i] = int'(state);
      if (tick && first < 0) first = i;
    end
    chk("step_latency", first, D + 3);
    chk("step_pre_state", st_log[D + 2], 0);
    chk("step_state", st_log[D + 3], 1);
    chk("step_wait_state", st_log[D + 4], 2);
    chk("step_ticks", tick_cnt, 1);
    step_btn_n = 1'b1; rel = -1;
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (state == 2'd0 && rel < 0) rel = i;
    end
    chk("release_late", (rel >= D) ? 1 : 0, 1);
    chk("release_cycle", rel, D + 2);

    // Bounce never settles long enough to be accepted.
    tick_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step_btn_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      cycle();
    end
    step_btn_n = 1'b1;
    repeat (10) cycle();
    chk("bounce_ticks", tick_cnt, 0);
    chk("bounce_state", state, 0);

    // Slow free-run.
    led0 = int'(tick_led); entry = -1;
    q.delete();
    mode_run = 1'b1; speed_fast = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (state == 2'd3 && entry < 0) entry = i;
      if (tick) q.push_back(i);
    end
    chk("run_entry", entry, 2);
    chk("run_nticks", q.size(), 3);
    if (q.size() == 3) begin
      chk("run_first", q[0] - entry, SLOW);
      chk("run_gap1", q[1] - q[0], SLOW);
      chk("run_gap2", q[2] - q[1], SLOW);
    end
    chk("run_led", tick_led, led0 ^ 1);

    // Switch to fast with the divider at 6.
    t = 0;
    while (!tick && t < 30) begin cycle(); t++; end
    chk("run_tick_seen", tick, 1);
    repeat (6) cycle();
    speed_fast = 1'b1;
    q.delete();
    for (int j = 0; j < 10; j++) begin
      cycle();
      if (tick) q.push_back(j);
    end
    chk("fast_nticks", q.size(), 3);
    if (q.size() == 3) begin
      chk("fast_first", q[0], 2);
      chk("fast_gap1", q[1] - q[0], FAST);
      chk("fast_gap2", q[2] - q[1], FAST);
    end

    // Button held during RUN, then leave RUN.
    step_btn_n = 1'b0;
    q.delete();
    for (int j = 0; j < 12; j++) begin
      cycle();
      if (tick) q.push_back(j);
    end
    for (int k = 1; k < q.size(); k++) chk("held_gap", q[k] - q[k-1], FAST);
    mode_run = 1'b0;
    for (int j = 0; j < 4; j++) begin
      cycle();
      st_log[j] = int'(state); tk_log[j] = int'(tick);
    end
    chk("exit_pre_state", st_log[1], 3);
    chk("exit_state", st_log[2], 2);
    chk("exit_tick", tk_log[2], 0);
    tick_cnt = 0;
    repeat (6) cycle();
    chk("held_wait_state", state, 2);
    step_btn_n = 1'b1;
    repeat (10) cycle();
    chk("after_rel_state", state, 0);
    chk("after_rel_ticks", tick_cnt, 0);

    // Async reset one cycle ahead of a scheduled slow tick.
    speed_fast = 1'b0; mode_run = 1'b1;
    repeat (3) cycle();
    t = 0;
    while (!tick && t < 30) begin cycle(); t++; end
    chk("pre_rst_tick", tick, 1);
    repeat (SLOW - 1) cycle();
    #2 reset_n = 1'b0;
    #1;
    chk("async_tick", tick, 0);
    chk("async_led", tick_led, 0);
    chk("async_state", state, 0);
    model_reset();
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      chk("rst_hold_tick", tick, 0);
    end
    reset_n = 1'b1;
    repeat (25) cycle();

    // Random mix against the model.
    mode_run = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) step_btn_n = ~step_btn_n;
      if ($urandom_range(0, 79) == 0) mode_run = ~mode_run;
      if ($urandom_range(0, 39) == 0) speed_fast = ~speed_fast;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
